// File: rtl/bnn_slice_packer.sv
// rtl/bnn_slice_packer.sv - packs per-channel BNN result slices into RAM words
// Optional feature macro: PACKER_MSB_FIRST_EN (first slice in the word MSBs; default LSB-first)
module bnn_slice_packer #(
   parameter int NCH  = 2,
   parameter int SW   = 8,
   parameter int OW   = 48,
   parameter int AW   = 9,
   parameter int SELW = 1
) (
   input  logic              iCLK,
   input  logic              iRSTn,
   input  logic              iSTART,
   input  logic [AW-1:0]     iBASE,
   input  logic [SELW-1:0]   iSEL,
   input  logic [NCH-1:0]    iVALID,
   input  logic [NCH*SW-1:0] iDATA,
   input  logic              iFLUSH,
   input  logic              iSTOP,
   input  logic              iWR_GNT,
   output logic              oREADY,
   output logic              oWR_EN,
   output logic [AW-1:0]     oWADDR,
   output logic [OW-1:0]     oWDATA,
   output logic              oBUSY,
   output logic              oOVF
);

   localparam int PACK = OW / SW;
   localparam int CW   = $clog2(PACK + 1);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, STOP_WR} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_ins;
   logic            stop_pend;
   logic [SW-1:0]   slice;
   logic            sel_valid;
   logic [OW-1:0]   word_ins;
   logic            go_wr;

   // pick the slice and strobe of the active channel; other channels are ignored
   always_comb begin
      slice     = '0;
      sel_valid = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (iSEL == SELW'(k)) begin
            slice     = iDATA[k*SW +: SW];
            sel_valid = iVALID[k];
         end
      end
   end

   // word and count as they would be after accepting the current slice
   always_comb begin
      word_ins = oWDATA;
      for (int i = 0; i < PACK; i++) begin
         if (cnt == CW'(i)) begin
`ifdef PACKER_MSB_FIRST_EN
            word_ins[OW-1-i*SW -: SW] = slice;
`else
            word_ins[i*SW +: SW] = slice;
`endif
         end
      end
      cnt_ins = cnt + CW'(sel_valid);
      go_wr   = (cnt_ins == CW'(PACK)) || ((iFLUSH || iSTOP) && (cnt_ins != '0));
   end

   // session FSM; oWADDR/oWDATA are the address and word registers themselves
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state     <= IDLE;
         cnt       <= '0;
         stop_pend <= 1'b0;
         oWADDR    <= '0;
         oWDATA    <= '0;
         oREADY    <= 1'b0;
         oWR_EN    <= 1'b0;
         oBUSY     <= 1'b0;
         oOVF      <= 1'b0;
      end else if (iSTART) begin
         state     <= FILL;
         cnt       <= '0;
         stop_pend <= 1'b0;
         oWADDR    <= iBASE;
         oWDATA    <= '0;
         oREADY    <= 1'b1;
         oWR_EN    <= 1'b0;
         oBUSY     <= 1'b1;
         oOVF      <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (sel_valid) begin
                  oWDATA <= word_ins;
                  cnt    <= cnt_ins;
               end
               if (go_wr) begin
                  state  <= iSTOP ? STOP_WR : WRITE;
                  oWR_EN <= 1'b1;
                  oREADY <= 1'b0;
               end else if (iSTOP) begin
                  state  <= IDLE;
                  oREADY <= 1'b0;
                  oBUSY  <= 1'b0;
               end
            end
            WRITE, STOP_WR: begin
               if (sel_valid) oOVF <= 1'b1;
               if (iSTOP) stop_pend <= 1'b1;
               if (iWR_GNT) begin
                  oWADDR    <= oWADDR + AW'(1);
                  oWDATA    <= '0;
                  cnt       <= '0;
                  oWR_EN    <= 1'b0;
                  stop_pend <= 1'b0;
                  if (state == STOP_WR || stop_pend || iSTOP) begin
                     state  <= IDLE;
                     oREADY <= 1'b0;
                     oBUSY  <= 1'b0;
                  end else begin
                     state  <= FILL;
                     oREADY <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
